// File: rtl/edge_period_meter_pkg.sv
// Receiver common types: measurement FSM states and
// an all-ones count helper for saturating counters.
package edge_period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   function automatic logic [63:0] all_ones(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/edge_period_meter_if.sv
// Period result stream: valid/ready handshake carrying
// the measured period in clk cycles.
interface edge_period_meter_if #(
   parameter int DW = 16
);
   logic [DW-1:0] period_o;
   logic          valid_o;
   logic          ready_i;

   modport master (
      output period_o,
      output valid_o,
      input  ready_i
   );

   modport slave (
      input  period_o,
      input  valid_o,
      output ready_i
   );
endinterface

// File: rtl/edge_period_meter_sync_edge_detect.sv
// Multi-flop synchroniser followed by a rising-edge
// detector; shared by the receiver front-end stages.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);
   logic [SYNC_STAGES-1:0] sff;
   logic                   level_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sff     <= '0;
         level_d <= 1'b0;
      end else begin
         sff     <= {sff[SYNC_STAGES-2:0], async_i};
         level_d <= sff[SYNC_STAGES-1];
      end
   end

   assign level_o = sff[SYNC_STAGES-1];
   assign rise_o  = level_o & ~level_d;
endmodule

// File: rtl/edge_period_meter.sv
// Rising-edge period meter: glitch reject, saturation
// timeout and a valid/ready result with sticky overrun.
module edge_period_meter
   import edge_period_meter_pkg::*;
#(
   parameter int DW          = 16,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_PERIOD  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   input  logic sig_i,
   output logic timeout_o,
   output logic overrun_o,
   edge_period_meter_if.master res
);
   localparam logic [DW-1:0] CNT_MAX = DW'(all_ones(DW));
   localparam logic [DW-1:0] MIN_CNT = DW'(MIN_PERIOD);

   state_t        state;
   state_t        state_n;
   logic [DW-1:0] cnt;
   logic [DW-1:0] cnt_n;
   logic [DW-1:0] period_q;
   logic          valid_q;
   logic          valid_n;
   logic          overrun_n;
   logic          rise;
   logic          cap;
   logic          load;
   logic          drop;
   logic          sig_level_unused;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (sig_i),
      .level_o (sig_level_unused),
      .rise_o  (rise)
   );

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      cap       = 1'b0;
      timeout_o = 1'b0;
      if (!en_i) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = ARM;
               cnt_n   = '0;
            end
            ARM: begin
               if (rise) begin
                  state_n = MEASURE;
                  cnt_n   = DW'(1);
               end
            end
            MEASURE: begin
               if (rise && cnt >= MIN_CNT) begin
                  cap   = 1'b1;
                  cnt_n = DW'(1);
               end else if (cnt == CNT_MAX) begin
                  // saturated: restart from ARM so no result spans the gap
                  timeout_o = 1'b1;
                  cnt_n     = '0;
                  state_n   = ARM;
               end else begin
                  cnt_n = cnt + DW'(1);
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_comb begin
      load      = cap & (~valid_q | res.ready_i);
      drop      = cap & valid_q & ~res.ready_i;
      valid_n   = valid_q;
      overrun_n = overrun_o;
      if (load) begin
         valid_n = 1'b1;
      end else if (valid_q & res.ready_i) begin
         valid_n = 1'b0;
      end
      if (drop) begin
         overrun_n = 1'b1;
      end else if (clr_i) begin
         overrun_n = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         valid_q   <= valid_n;
         overrun_o <= overrun_n;
         if (load) begin
            period_q <= cnt;
         end
      end
   end

   assign res.period_o = period_q;
   assign res.valid_o  = valid_q;
endmodule

// File: tb/tb_edge_period_meter.sv
// Bench for edge_period_meter: scenario tasks plus a
// timestamp-based reference model of the measured periods.
module tb_edge_period_meter;
   localparam int DW   = 8;
   localparam int MINP = 4;
   localparam int MAXC = 255;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic clr = 1'b0;
   logic sig = 1'b0;
   logic rdy = 1'b0;
   logic timeout;
   logic overrun;

   int tests = 0;
   int fails = 0;

   edge_period_meter_if #(.DW(DW)) bus ();
   assign bus.ready_i = rdy;

   edge_period_meter #(
      .DW(DW),
      .SYNC_STAGES(2),
      .MIN_PERIOD(MINP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .clr_i     (clr),
      .sig_i     (sig),
      .timeout_o (timeout),
      .overrun_o (overrun),
      .res       (bus)
   );

   always #5 clk = ~clk;

   // Reference model: an edge is seen two samples after sig rises;
   // a result is the distance between accepted edge timestamps.
   int         n = 0;
   int         ref_t;
   int         mode;
   int         el;
   int         val;
   logic [2:0] sh;
   logic       edge_now;
   logic       cap;
   logic       m_valid;
   logic       m_overrun;
   logic       m_tmo;
   logic       dut_tmo;
   logic [7:0] m_period;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sh        = '0;
         mode      = 0;
         ref_t     = 0;
         m_valid   = 1'b0;
         m_period  = '0;
         m_overrun = 1'b0;
         m_tmo     = 1'b0;
         dut_tmo   = 1'b0;
      end else begin
         n++;
         dut_tmo  = timeout;
         edge_now = sh[1] & ~sh[2];
         cap      = 1'b0;
         m_tmo    = 1'b0;
         if (!en) begin
            mode = 0;
         end else if (mode == 0) begin
            mode = 1;
         end else if (mode == 1) begin
            if (edge_now) begin
               ref_t = n;
               mode  = 2;
            end
         end else begin
            el = n - ref_t;
            if (edge_now && el >= MINP) begin
               cap   = 1'b1;
               val   = el;
               ref_t = n;
            end else if (el == MAXC) begin
               m_tmo = 1'b1;
               mode  = 1;
            end
         end
         if (cap && m_valid && !rdy) m_overrun = 1'b1;
         else if (clr) m_overrun = 1'b0;
         if (cap && (!m_valid || rdy)) begin
            m_valid  = 1'b1;
            m_period = 8'(val);
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
         end
         sh = {sh[1:0], sig};
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      tests++;
      if ({bus.valid_o, bus.period_o, overrun, timeout} !== 11'd0) begin
         fails++;
         $display("FAIL reset v=%b p=%0d o=%b t=%b want all 0",
                  bus.valid_o, bus.period_o, overrun, timeout);
      end
      rst = 1'b0;
      tick();
      tests++;
      if ({bus.valid_o, bus.period_o, overrun, timeout} !== 11'd0) begin
         fails++;
         $display("FAIL reset_release v=%b p=%0d o=%b t=%b want all 0",
                  bus.valid_o, bus.period_o, overrun, timeout);
      end
   endtask

   task automatic test_periodic(input string tag, input int nrand);
      int gaps[$];
      logic       ev;
      en  = 1'b1;
      rdy = 1'b1;
      clr = 1'b0;
      sig = 1'b0;
      repeat (3) tick();
      gaps = {20, 20, 20, 20};
      for (int r = 0; r < nrand; r++) gaps.push_back($urandom_range(6, 60));
      foreach (gaps[k]) begin
         for (int i = 0; i < gaps[k]; i++) begin
            sig = (i < gaps[k] / 2);
            tick();
            tests++;
            if (bus.valid_o !== m_valid || bus.period_o !== m_period ||
                overrun !== m_overrun || dut_tmo !== m_tmo) begin
               fails++;
               $display("FAIL %s_model v=%b/%b p=%0d/%0d o=%b/%b t=%b/%b @%0t",
                        tag, bus.valid_o, m_valid, bus.period_o, m_period,
                        overrun, m_overrun, dut_tmo, m_tmo, $time);
            end
            ev = (k > 0 && i == 2);
            tests++;
            if (bus.valid_o !== ev ||
                (ev && bus.period_o !== 8'(gaps[k-1]))) begin
               fails++;
               $display("FAIL %s_period seg=%0d i=%0d v=%b p=%0d want v=%b p=%0d",
                        tag, k, i, bus.valid_o, bus.period_o, ev,
                        (k > 0) ? gaps[k-1] : 0);
            end
         end
      end
   endtask

   task automatic test_glitch();
      int gaps[$];
      int got[$];
      gaps = {20, 2, 10, 20};
      rdy  = 1'b1;
      foreach (gaps[k]) begin
         for (int i = 0; i < gaps[k]; i++) begin
            sig = (i < gaps[k] / 2);
            tick();
            tests++;
            if (bus.valid_o !== m_valid || bus.period_o !== m_period ||
                overrun !== m_overrun || dut_tmo !== m_tmo) begin
               fails++;
               $display("FAIL glitch_model v=%b/%b p=%0d/%0d o=%b/%b t=%b/%b @%0t",
                        bus.valid_o, m_valid, bus.period_o, m_period,
                        overrun, m_overrun, dut_tmo, m_tmo, $time);
            end
            if (bus.valid_o === 1'b1) got.push_back(int'(bus.period_o));
         end
      end
      tests++;
      if (got.size() != 3) begin
         fails++;
         $display("FAIL glitch_count results=%0d want 3", got.size());
      end else if (got[1] != 20 || got[2] != 12) begin
         fails++;
         $display("FAIL glitch_values got %0d,%0d want 20,12", got[1], got[2]);
      end
   endtask

   task automatic test_timeout();
      int got[$];
      int gaps[$];
      int jv = -1;
      int jt = -1;
      int nto = 0;
      rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         sig = (i < 5);
         tick();
         tests++;
         if (bus.valid_o !== m_valid || bus.period_o !== m_period ||
             overrun !== m_overrun || dut_tmo !== m_tmo) begin
            fails++;
            $display("FAIL timeout_model v=%b/%b p=%0d/%0d o=%b/%b t=%b/%b @%0t",
                     bus.valid_o, m_valid, bus.period_o, m_period,
                     overrun, m_overrun, dut_tmo, m_tmo, $time);
         end
         if (bus.valid_o === 1'b1) jv = i;
         if (dut_tmo === 1'b1) begin
            nto++;
            jt = i;
         end
      end
      tests++;
      if (nto != 1 || jt - jv != MAXC) begin
         fails++;
         $display("FAIL timeout_pulse count=%0d delay=%0d want 1 and %0d",
                  nto, jt - jv, MAXC);
      end
      gaps = {25, 12};
      foreach (gaps[k]) begin
         for (int i = 0; i < gaps[k]; i++) begin
            sig = (i < gaps[k] / 2);
            tick();
            tests++;
            if (bus.valid_o !== m_valid || bus.period_o !== m_period ||
                overrun !== m_overrun || dut_tmo !== m_tmo) begin
               fails++;
               $display("FAIL rearm_model v=%b/%b p=%0d/%0d o=%b/%b t=%b/%b @%0t",
                        bus.valid_o, m_valid, bus.period_o, m_period,
                        overrun, m_overrun, dut_tmo, m_tmo, $time);
            end
            if (bus.valid_o === 1'b1) got.push_back(int'(bus.period_o));
         end
      end
      tests++;
      if (got.size() != 1 || got[0] != 25) begin
         fails++;
         $display("FAIL rearm_result count=%0d first=%0d want 1 result of 25",
                  got.size(), (got.size() > 0) ? got[0] : -1);
      end
   endtask

   task automatic test_backpressure();
      int gaps[$];
      rdy = 1'b1;
      en  = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      repeat (3) tick();
      rdy  = 1'b0;
      gaps = {30, 30, 30};
      foreach (gaps[k]) begin
         for (int i = 0; i < gaps[k]; i++) begin
            sig = (i < gaps[k] / 2);
            tick();
            tests++;
            if (bus.valid_o !== m_valid || bus.period_o !== m_period ||
                overrun !== m_overrun || dut_tmo !== m_tmo) begin
               fails++;
               $display("FAIL backpressure_model v=%b/%b p=%0d/%0d o=%b/%b t=%b/%b @%0t",
                        bus.valid_o, m_valid, bus.period_o, m_period,
                        overrun, m_overrun, dut_tmo, m_tmo, $time);
            end
         end
      end
      tests++;
      if (bus.valid_o !== 1'b1 || bus.period_o !== 8'd30 || overrun !== 1'b1) begin
         fails++;
         $display("FAIL backpressure_hold v=%b p=%0d o=%b want 1 30 1",
                  bus.valid_o, bus.period_o, overrun);
      end
      rdy = 1'b1;
      tick();
      tests++;
      if (bus.valid_o !== 1'b0 || bus.period_o !== 8'd30 || overrun !== 1'b1) begin
         fails++;
         $display("FAIL backpressure_accept v=%b p=%0d o=%b want 0 30 1",
                  bus.valid_o, bus.period_o, overrun);
      end
      rdy = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_clear o=%b want 0", overrun);
      end
   endtask

   task automatic test_disable();
      int         gaps[$];
      int         got[$];
      logic [7:0] pv = '0;
      rdy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         sig = (i < 6);
         tick();
         if (i == 2) pv = m_period;
      end
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         tests++;
         if (bus.valid_o !== m_valid || bus.period_o !== m_period ||
             overrun !== m_overrun || dut_tmo !== m_tmo) begin
            fails++;
            $display("FAIL disable_model v=%b/%b p=%0d/%0d o=%b/%b t=%b/%b @%0t",
                     bus.valid_o, m_valid, bus.period_o, m_period,
                     overrun, m_overrun, dut_tmo, m_tmo, $time);
         end
      end
      tests++;
      if (bus.valid_o !== 1'b1 || bus.period_o !== pv) begin
         fails++;
         $display("FAIL disable_retain v=%b p=%0d want 1 %0d",
                  bus.valid_o, bus.period_o, pv);
      end
      rdy = 1'b1;
      tick();
      tests++;
      if (bus.valid_o !== 1'b0) begin
         fails++;
         $display("FAIL disable_accept v=%b want 0", bus.valid_o);
      end
      en = 1'b1;
      repeat (2) tick();
      gaps = {40, 40, 40};
      foreach (gaps[k]) begin
         for (int i = 0; i < gaps[k]; i++) begin
            sig = (i < gaps[k] / 2);
            tick();
            tests++;
            if (bus.valid_o !== m_valid || bus.period_o !== m_period ||
                overrun !== m_overrun || dut_tmo !== m_tmo) begin
               fails++;
               $display("FAIL reenable_model v=%b/%b p=%0d/%0d o=%b/%b t=%b/%b @%0t",
                        bus.valid_o, m_valid, bus.period_o, m_period,
                        overrun, m_overrun, dut_tmo, m_tmo, $time);
            end
            if (bus.valid_o === 1'b1) got.push_back(int'(bus.period_o));
         end
      end
      tests++;
      if (got.size() != 2 || got[0] != 40 || got[1] != 40) begin
         fails++;
         $display("FAIL reenable_results count=%0d want two results of 40",
                  got.size());
      end
   endtask

   task automatic test_random();
      int g;
      int pick;
      for (int s = 0; s < 40; s++) begin
         pick = $urandom_range(0, 11);
         if (pick == 0) g = 255;
         else if (pick == 1) g = $urandom_range(240, 275);
         else g = $urandom_range(2, 40);
         en = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < g; i++) begin
            sig = (i < g / 2);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            tick();
            tests++;
            if (bus.valid_o !== m_valid || bus.period_o !== m_period ||
                overrun !== m_overrun || dut_tmo !== m_tmo) begin
               fails++;
               $display("FAIL random_model v=%b/%b p=%0d/%0d o=%b/%b t=%b/%b @%0t",
                        bus.valid_o, m_valid, bus.period_o, m_period,
                        overrun, m_overrun, dut_tmo, m_tmo, $time);
            end
         end
      end
      clr = 1'b0;
   endtask

   task automatic test_async_reset();
      en  = 1'b1;
      rdy = 1'b0;
      clr = 1'b0;
      for (int i = 0; i < 70; i++) begin
         sig = ((i % 20) < 10);
         tick();
      end
      sig = 1'b0;
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({bus.valid_o, bus.period_o, overrun, timeout} !== 11'd0) begin
         fails++;
         $display("FAIL async_reset v=%b p=%0d o=%b t=%b want all 0",
                  bus.valid_o, bus.period_o, overrun, timeout);
      end
      @(negedge clk);
      rst = 1'b0;
      test_periodic("after_reset", 0);
   endtask

   initial begin
      test_reset();
      test_periodic("periodic", 8);
      test_glitch();
      test_timeout();
      test_backpressure();
      test_disable();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
